// File: rtl/link_pkg.sv
// link_pkg: definitions shared by the link transmitter and receiver.
//   LINK_WORD_W  : bits per frame
//   LINK_MIN_GAP : smallest GAP value (cycles since the previous SYNC) at
//                  which a new SYNC is still a well-formed frame
//   link_word_t  : one frame, index 0 is the first bit on the wire
package link_pkg;
   localparam int LINK_WORD_W  = 16;
   localparam int LINK_MIN_GAP = 15;
   typedef logic [0:LINK_WORD_W-1] link_word_t;
endpackage

// File: rtl/link_receiver_if.sv
// link_receiver_if: consumer-side valid/ready word handshake.
//   RX_DATA  : head-of-FIFO word (index 0 = first bit received)
//   RX_VALID : RX_DATA is meaningful
//   RX_READY : consumer takes RX_DATA this cycle
// master = receiver side, slave = consumer side.
interface link_receiver_if;
   import link_pkg::*;
   link_word_t RX_DATA;
   logic       RX_VALID;
   logic       RX_READY;

   modport master (output RX_DATA, output RX_VALID, input RX_READY);
   modport slave  (input RX_DATA, input RX_VALID, output RX_READY);
endinterface

// File: rtl/link_rx_fifo.sv
// link_rx_fifo: show-ahead word FIFO for the link receiver.
//   LINK_CLK, RESETN : clock, async active-low reset (clears storage too)
//   push, wdata      : write request; taken when not full, or full with a pop
//   pop              : read request; ignored when empty
//   rdata            : entry at the read pointer (show-ahead)
//   full, empty      : occupancy status
//   level            : number of words held
module link_rx_fifo
   import link_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   localparam int AW = $clog2(FIFO_DEPTH)
) (
   input  logic       LINK_CLK,
   input  logic       RESETN,
   input  logic       push,
   input  link_word_t wdata,
   input  logic       pop,
   output link_word_t rdata,
   output logic       full,
   output logic       empty,
   output logic [AW:0] level
);
   link_word_t  mem_q [FIFO_DEPTH];
   link_word_t  mem_d [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push, do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level = wr_ptr_q - rd_ptr_q;
   assign rdata = mem_q[rd_ptr_q[AW-1:0]];

   assign do_pop  = pop && !empty;
   // A pop frees the slot this cycle, so a full FIFO can still take a push.
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = wdata;
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop)
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge LINK_CLK or negedge RESETN) begin
      if (!RESETN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end
endmodule

// File: rtl/link_receiver.sv
// link_receiver: deserializer for the 16-bit framed serial link.
// Bits are shifted in every cycle; a SYNC pulse on the last bit of a frame
// captures the word into a show-ahead FIFO read over a valid/ready handshake.
//   LINK_CLK, RESETN : clock, async active-low reset
//   S_IN, SYNC       : serial data and end-of-frame pulse from the transmitter
//   rx               : RX_DATA / RX_VALID / RX_READY consumer handshake
//   FIFO_LEVEL       : words buffered
//   OVERFLOW         : sticky, a word was dropped on a full FIFO
//   FRAME_ERR        : sticky, SYNC came too soon after the previous one
//   CLR_ERR          : clears both sticky flags (a same-cycle set wins)
// Build option LINK_RX_FRAME_CHECK_EN: enables the SYNC spacing check;
// without it every SYNC pushes a word and FRAME_ERR is constant 0.
module link_receiver
   import link_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          LINK_CLK,
   input  logic                          RESETN,
   input  logic                          S_IN,
   input  logic                          SYNC,
   link_receiver_if.master               rx,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
   output logic                          OVERFLOW,
   output logic                          FRAME_ERR,
   input  logic                          CLR_ERR
);
   link_word_t shift_q, shift_d;
   logic       overflow_q, overflow_d;
   logic       accept;
   logic       pop;
   logic       fifo_full, fifo_empty;

   // The word captured on SYNC is the shift register's next value, so the
   // bit on the wire in the SYNC cycle lands in the last position.
   always_comb shift_d = {shift_q[1:LINK_WORD_W-1], S_IN};

`ifdef LINK_RX_FRAME_CHECK_EN
   logic [4:0] gap_q, gap_d;
   logic       frame_err_q, frame_err_d;

   always_comb begin
      gap_d = gap_q;
      if (SYNC)
         gap_d = '0;
      else if (gap_q != 5'd31)
         gap_d = gap_q + 5'd1;
   end

   assign accept = SYNC && (gap_q >= 5'(LINK_MIN_GAP));

   always_comb begin
      frame_err_d = frame_err_q;
      if (CLR_ERR)
         frame_err_d = 1'b0;
      if (SYNC && !accept)
         frame_err_d = 1'b1;
   end

   always_ff @(posedge LINK_CLK or negedge RESETN) begin
      if (!RESETN) begin
         gap_q       <= '0;
         frame_err_q <= 1'b0;
      end else begin
         gap_q       <= gap_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign FRAME_ERR = frame_err_q;
`else
   assign accept    = SYNC;
   assign FRAME_ERR = 1'b0;
`endif

   assign pop      = rx.RX_VALID && rx.RX_READY;
   assign rx.RX_VALID = !fifo_empty;

   always_comb begin
      overflow_d = overflow_q;
      if (CLR_ERR)
         overflow_d = 1'b0;
      if (accept && fifo_full && !pop)
         overflow_d = 1'b1;
   end

   always_ff @(posedge LINK_CLK or negedge RESETN) begin
      if (!RESETN) begin
         shift_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         shift_q    <= shift_d;
         overflow_q <= overflow_d;
      end
   end

   assign OVERFLOW = overflow_q;

   link_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .LINK_CLK (LINK_CLK),
      .RESETN   (RESETN),
      .push     (accept),
      .wdata    (shift_d),
      .pop      (pop),
      .rdata    (rx.RX_DATA),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (FIFO_LEVEL)
   );
endmodule

// File: tb/tb_link_receiver.sv
// tb_link_receiver: directed scenarios plus randomized frames for
// link_receiver, checked every cycle against a queue-based model.
module tb_link_receiver;
   import link_pkg::*;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          LINK_CLK = 1'b0;
   logic          RESETN   = 1'b0;
   logic          S_IN     = 1'b0;
   logic          SYNC     = 1'b0;
   logic          CLR_ERR  = 1'b0;
   logic [LW-1:0] FIFO_LEVEL;
   logic          OVERFLOW, FRAME_ERR;

   link_receiver_if rx_if ();

   link_receiver #(.FIFO_DEPTH(DEPTH)) dut (
      .LINK_CLK   (LINK_CLK),
      .RESETN     (RESETN),
      .S_IN       (S_IN),
      .SYNC       (SYNC),
      .rx         (rx_if),
      .FIFO_LEVEL (FIFO_LEVEL),
      .OVERFLOW   (OVERFLOW),
      .FRAME_ERR  (FRAME_ERR),
      .CLR_ERR    (CLR_ERR)
   );

   always #5 LINK_CLK = ~LINK_CLK;

   int checks = 0;
   int errors = 0;

   // Model: last 16 wire bits, cycle index of the last SYNC, word queue.
   logic [15:0] m_hist;
   int          m_cyc;
   int          m_last_sync;
   logic [15:0] m_q [$];
   bit          m_ovf, m_ferr;
   bit          chk_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      m_hist = '0;
      m_cyc = 0;
      m_last_sync = -1;
      m_q.delete();
      m_ovf = 1'b0;
      m_ferr = 1'b0;
   endtask

   task automatic m_step(input bit s, input bit y, input bit r, input bit c);
      logic [15:0] w;
      bit acc, pop;
      w = {m_hist[14:0], s};
      m_hist = w;
      acc = y;
`ifdef LINK_RX_FRAME_CHECK_EN
      // cycles strictly between the previous SYNC (or reset) and this one
      if (y && (m_cyc - m_last_sync - 1) < LINK_MIN_GAP) acc = 1'b0;
`endif
      pop = (m_q.size() > 0) && r;
      if (c) begin
         m_ovf = 1'b0;
         m_ferr = 1'b0;
      end
      if (y && !acc) m_ferr = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
         if (m_q.size() < DEPTH) m_q.push_back(w);
         else m_ovf = 1'b1;
      end
      if (y) m_last_sync = m_cyc;
      m_cyc++;
   endtask

   always @(negedge LINK_CLK) begin
      if (chk_on && RESETN) begin
         chk("valid", rx_if.RX_VALID, m_q.size() > 0);
         chk("level", FIFO_LEVEL, m_q.size());
         chk("overflow", OVERFLOW, m_ovf);
         chk("frame_err", FRAME_ERR, m_ferr);
         if (m_q.size() > 0) chk("data", rx_if.RX_DATA, m_q[0]);
      end
   end

   // One clock: drive inputs, let the edge happen, return at negedge+1.
   task automatic cyc(input bit s, input bit y, input bit r, input bit c);
      S_IN = s; SYNC = y; rx_if.RX_READY = r; CLR_ERR = c;
      @(posedge LINK_CLK);
      m_step(s, y, r, c);
      @(negedge LINK_CLK);
      #1;
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, r, 1'b0);
   endtask

   // nbits bits MSB first, SYNC on the last; rb = ready on data bits,
   // rs = ready on the SYNC bit; then idle cycles with ready = rb.
   task automatic send_word(input logic [15:0] w, input int nbits, input bit rb,
                            input bit rs, input int n_idle);
      for (int i = 0; i < nbits; i++)
         cyc(w[15-i], i == nbits-1, (i == nbits-1) ? rs : rb, 1'b0);
      idle(n_idle, rb);
   endtask

   task automatic drain_expect(input string name, input logic [15:0] w);
      chk(name, rx_if.RX_DATA, w);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      RESETN = 1'b0;
      m_reset();
      S_IN = 1'b0; SYNC = 1'b0; rx_if.RX_READY = 1'b0; CLR_ERR = 1'b0;
      repeat (2) @(negedge LINK_CLK);
      #1 RESETN = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, rx_if.RX_VALID, 0);
      chk({tag, "_data"}, rx_if.RX_DATA, 0);
      chk({tag, "_level"}, FIFO_LEVEL, 0);
      chk({tag, "_ovf"}, OVERFLOW, 0);
      chk({tag, "_ferr"}, FRAME_ERR, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rw;
      int nb;
      rx_if.RX_READY = 1'b0;
      do_reset();
      chk_on = 1'b1;
      chk_reset_vals("reset");
      idle(16, 1'b0);

      // single frame, one-cycle latency, then pop
      send_word(16'hA5C3, 16, 1'b0, 1'b0, 0);
      chk("t1_valid", rx_if.RX_VALID, 1);
      chk("t1_data", rx_if.RX_DATA, 16'hA5C3);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t1_empty", rx_if.RX_VALID, 0);

      // three frames at 17-cycle period, no reads
      idle(1, 1'b0);
      send_word(16'h0001, 16, 1'b0, 1'b0, 1);
      send_word(16'h8000, 16, 1'b0, 1'b0, 1);
      send_word(16'hFFFF, 16, 1'b0, 1'b0, 1);
      chk("t2_level", FIFO_LEVEL, 3);
      drain_expect("t2_w0", 16'h0001);
      drain_expect("t2_w1", 16'h8000);
      drain_expect("t2_w2", 16'hFFFF);
      chk("t2_empty", rx_if.RX_VALID, 0);

      // five frames into a depth-4 FIFO: fifth dropped
      send_word(16'h1111, 16, 1'b0, 1'b0, 1);
      send_word(16'h2222, 16, 1'b0, 1'b0, 1);
      send_word(16'h3333, 16, 1'b0, 1'b0, 1);
      send_word(16'h4444, 16, 1'b0, 1'b0, 1);
      send_word(16'h5555, 16, 1'b0, 1'b0, 0);
      chk("t3_level", FIFO_LEVEL, 4);
      chk("t3_ovf", OVERFLOW, 1);
      chk("t3_head", rx_if.RX_DATA, 16'h1111);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t3_clr", OVERFLOW, 0);
      drain_expect("t3_w0", 16'h1111);
      drain_expect("t3_w1", 16'h2222);
      drain_expect("t3_w2", 16'h3333);
      drain_expect("t3_w3", 16'h4444);
      chk("t3_empty", rx_if.RX_VALID, 0);

      // push into a full FIFO coincident with a pop
      send_word(16'hA001, 16, 1'b0, 1'b0, 1);
      send_word(16'hA002, 16, 1'b0, 1'b0, 1);
      send_word(16'hA003, 16, 1'b0, 1'b0, 1);
      send_word(16'hA004, 16, 1'b0, 1'b0, 1);
      send_word(16'hBEEF, 16, 1'b0, 1'b1, 0);
      chk("t4_ovf", OVERFLOW, 0);
      chk("t4_level", FIFO_LEVEL, 4);
      drain_expect("t4_w0", 16'hA002);
      drain_expect("t4_w1", 16'hA003);
      drain_expect("t4_w2", 16'hA004);
      drain_expect("t4_w3", 16'hBEEF);

      // SYNC 10 cycles after the previous one
      idle(1, 1'b0);
      send_word(16'h1234, 16, 1'b0, 1'b0, 0);
      send_word(16'hC0DE, 10, 1'b0, 1'b0, 0);
`ifdef LINK_RX_FRAME_CHECK_EN
      chk("t5_level", FIFO_LEVEL, 1);
      chk("t5_ferr", FRAME_ERR, 1);
`else
      chk("t5_level", FIFO_LEVEL, 2);
      chk("t5_ferr", FRAME_ERR, 0);
`endif
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      chk("t5_clr", FRAME_ERR, 0);
      idle(3, 1'b1);

      // back-to-back frames (SYNC period 16) are both accepted
      send_word(16'h0F0F, 16, 1'b0, 1'b0, 0);
      send_word(16'hF0F0, 16, 1'b0, 1'b0, 0);
      chk("t6_level", FIFO_LEVEL, 2);
      chk("t6_ferr", FRAME_ERR, 0);

      // reset after 8 bits with 2 words buffered
      for (int i = 0; i < 8; i++) cyc(rw[0], 1'b0, 1'b0, 1'b0);
      #2 RESETN = 1'b0;
      m_reset();
      #1 chk_reset_vals("t7_rst");
      repeat (2) @(negedge LINK_CLK);
      #1 RESETN = 1'b1;
      idle(16, 1'b0);
      send_word(16'h5A5A, 16, 1'b0, 1'b0, 0);
      chk("t7_valid", rx_if.RX_VALID, 1);
      chk("t7_data", rx_if.RX_DATA, 16'h5A5A);
      chk("t7_level", FIFO_LEVEL, 1);
      idle(2, 1'b1);

      // randomized frames, gaps, reads and clears
      for (int k = 0; k < 400; k++) begin
         rw = 16'($urandom);
         nb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 15)) : 16;
         for (int i = 0; i < nb; i++)
            cyc(rw[15-i], i == nb-1, $urandom_range(0, 9) < 4,
                $urandom_range(0, 19) == 0);
         for (int i = 0; i < int'($urandom_range(0, 3)); i++)
            cyc(1'b0, 1'b0, $urandom_range(0, 9) < 4, 1'b0);
      end
      idle(8, 1'b1);
      chk("final_empty", rx_if.RX_VALID, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/link_receiver.md
# link_receiver

Serial-link receiver for the 16-bit framed link driven by the link transmitter on the same LINK_CLK. It deserializes the serial data stream and uses the transmitter's end-of-frame SYNC pulse to delimit words. Assembled words are buffered in a small FIFO and offered to the consumer over a valid/ready handshake. Overflow and framing faults are reported as sticky status flags.

## Interface
- FIFO_DEPTH, 4, word buffer depth; power of two, ≥2
- LINK_CLK  input  1  link clock; all logic is on the rising edge
- RESETN  input  1  asynchronous, active-low reset
- S_IN  input  1  serial data from the transmitter's S_OUT; first bit of a word first
- SYNC  input  1  one-cycle pulse, coincident with the 16th (last) bit of a frame
- RX_DATA  output  [0:15]  head-of-FIFO word; index 0 is the first bit received
- RX_VALID  output  1  FIFO not empty; RX_DATA is meaningful
- RX_READY  input  1  consumer accepts RX_DATA this cycle
- FIFO_LEVEL  output  $clog2(FIFO_DEPTH)+1  number of words held
- OVERFLOW  output  1  sticky: a word was dropped because the FIFO was full
- FRAME_ERR  output  1  sticky: SYNC arrived before 16 bits had been received
- CLR_ERR  input  1  clears OVERFLOW and FRAME_ERR

## Operation
- Same clock domain as the transmitter; S_IN and SYNC are sampled directly, with no synchronizer.
- Shift register SHIFT[0:15]: each cycle, SHIFT <= {SHIFT[1:15], S_IN}. It shifts unconditionally, including during idle (idle S_IN = 0).
- Word capture in a SYNC cycle: W = {SHIFT[1:15], S_IN}, so the current bit lands in W[15].
- Gap counter GAP (5 bits, present only with the macro):
  - Set to 0 on a SYNC cycle; otherwise increments, saturating at 31.
  - SYNC is accepted when GAP ≥ 15. Otherwise W is discarded and FRAME_ERR is set.
- An accepted W is pushed into the FIFO.
  - Full with no pop in the same cycle: W is dropped and OVERFLOW is set. Existing contents are unchanged.
  - Full with a pop in the same cycle: the push succeeds and the level stays at FIFO_DEPTH.
- Pop occurs when RX_VALID && RX_READY. The FIFO is show-ahead: RX_DATA is always the entry at the read pointer.
- Pointers have log2(FIFO_DEPTH)+1 bits. Full when the MSBs differ and the low bits are equal; they wrap naturally.
- CLR_ERR clears both flags. If a new error occurs in the same cycle, the set wins.
- Reset values: SHIFT 0, GAP 0, FIFO empty (pointers 0, storage 0), RX_VALID 0, RX_DATA 16'h0000, FIFO_LEVEL 0, OVERFLOW 0, FRAME_ERR 0.
- Reset mid-frame discards the partial word and all buffered words.

## Timing
- Frame on the wire: 16 consecutive bit cycles, with SYNC high in the 16th. The transmitter inserts at least 1 idle cycle, giving a minimum SYNC period of 17 cycles.
- The receiver also tolerates a SYNC period of 16 (GAP = 15). A period of 15 or less is a framing error.
- After reset release, the first SYNC is accepted only if ≥15 cycles have elapsed. The transmitter's 16-cycle init guarantees this.
- Latency: with the FIFO empty, RX_VALID rises and RX_DATA is valid in the cycle immediately after the SYNC cycle.
- RX_VALID falls in the cycle after the pop of the last word, unless a push lands in the same edge.
- Flags assert in the cycle after the offending SYNC cycle.

## Configuration
- LINK_RX_FRAME_CHECK_EN defined: the GAP counter is present and framing is checked as above.
- Not defined: there is no GAP counter. Every SYNC pushes W regardless of spacing, and FRAME_ERR is tied to 0.

## Structure
- Package link_pkg holds:
  - LINK_WORD_W = 16
  - LINK_MIN_GAP = 15
  - typedef link_word_t ([0:15])
- It is shared with the transmitter.
- Sub-module link_rx_fifo (parameter FIFO_DEPTH) provides the show-ahead FIFO with push, pop, full, empty and level. The top level contains the deserializer, gap check and flags.

## Test plan
- Single frame 16'hA5C3, first bit = MSB '1', SYNC on bit 16 -> RX_VALID = 1 and RX_DATA = 16'hA5C3 one cycle after SYNC; RX_READY = 1 pops it and RX_VALID returns to 0.
- Three frames 16'h0001, 16'h8000, 16'hFFFF at a 17-cycle period, RX_READY = 0 -> FIFO_LEVEL = 3; the words then drain in order.
- Five frames with FIFO_DEPTH = 4 and RX_READY = 0 -> the 5th word is dropped, OVERFLOW = 1, and the FIFO holds the first four; CLR_ERR -> OVERFLOW = 0.
- Fifth frame's SYNC coincident with a pop while full -> no overflow, FIFO_LEVEL stays 4, and the 5th word is last out.
- SYNC asserted 10 cycles after the previous SYNC (macro on) -> word discarded, FRAME_ERR = 1, FIFO_LEVEL unchanged. With the macro off -> word pushed and FRAME_ERR = 0.
- RESETN pulsed low after 8 bits of a frame with 2 words buffered -> all outputs return to reset values, and the next complete frame is received correctly.
